// File: rtl/soc_network_adapter_config_wb_pkg.sv
// Shared definitions for the Wishbone-to-configuration-register adapter:
// FSM states, legal offset windows and the burst encodings it recognises.
package soc_optimsoc_configuration;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2,
    ST_ERROR  = 2'd3
  } cfg_state_t;

  // Readable windows; the first window starts at offset 0.
  localparam logic [11:0] RD0_HI    = 12'h02F;
  localparam logic [11:0] RD1_LO    = 12'h100;
  localparam logic [11:0] RD1_HI    = 12'h10B;
  localparam logic [11:0] RD2_LO    = 12'h200;
  localparam logic [11:0] RD2_HI    = 12'h27F;

  // The only register that may ever be written.
  localparam logic [11:0] WR_OFFSET = 12'h108;

  // Address step between consecutive beats of an incrementing burst.
  localparam logic [11:0] BEAT_STRIDE = 12'd4;

  localparam logic [2:0] CTI_INCR   = 3'b010;
  localparam logic [2:0] CTI_END    = 3'b111;
  localparam logic [1:0] BTE_LINEAR = 2'b00;

endpackage

// File: rtl/soc_network_adapter_config_wb_decode.sv
// Combinational legality check of one offset: reads must fall inside a
// readable window, writes must be a full-word write to the writable register.
module soc_network_adapter_config_decode
  import soc_optimsoc_configuration::*;
#(
  parameter int CDC_WRITABLE = 0
) (
  input  logic [11:0] i_offset,
  input  logic        i_we,
  input  logic [3:0]  i_sel,
  output logic        o_valid
);

  logic w_rd_ok;
  logic w_wr_ok;

  // Evaluate both read and write legality, then pick by direction.
  always_comb begin
    w_rd_ok = (i_offset <= RD0_HI) ||
              ((i_offset >= RD1_LO) && (i_offset <= RD1_HI)) ||
              ((i_offset >= RD2_LO) && (i_offset <= RD2_HI));
    w_wr_ok = (CDC_WRITABLE != 0) && (i_offset == WR_OFFSET) && (i_sel == 4'hF);
    o_valid = i_we ? w_wr_ok : w_rd_ok;
  end

endmodule

// File: rtl/soc_network_adapter_config_wb.sv
// Wishbone B3 slave that fronts a combinational configuration register
// block. Single accesses are acked one cycle after the request; incrementing
// linear bursts stream one beat per cycle from an internal offset counter.
module soc_network_adapter_config_wb
  import soc_optimsoc_configuration::*;
#(
  parameter int DW           = 32,
  parameter int AW           = 32,
  parameter int CDC_WRITABLE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o,
  output logic [15:0]   cfg_addr,
  output logic [DW-1:0] cfg_din,
  output logic          cfg_en,
  output logic          cfg_we,
  input  logic [DW-1:0] cfg_dout
);

  cfg_state_t    r_state;
  cfg_state_t    w_next;
  logic          r_ack;
  logic          r_err;
  logic [DW-1:0] r_dat;
  logic [11:0]   r_cnt;

  logic          w_ack_d;
  logic          w_err_d;
  logic [11:0]   w_cnt_d;
  logic [11:0]   w_offset;
  logic          w_cfg_en;
  logic          w_req_valid;
  logic          w_cnt_valid;
  logic          w_unused;

  // Only the low 12 address bits select a register.
  assign w_unused = ^wb_adr_i[AW-1:12];

  soc_network_adapter_config_decode #(.CDC_WRITABLE(CDC_WRITABLE)) u_req_decode (
    .i_offset (wb_adr_i[11:0]),
    .i_we     (wb_we_i),
    .i_sel    (wb_sel_i),
    .o_valid  (w_req_valid)
  );

  soc_network_adapter_config_decode #(.CDC_WRITABLE(CDC_WRITABLE)) u_cnt_decode (
    .i_offset (r_cnt),
    .i_we     (wb_we_i),
    .i_sel    (wb_sel_i),
    .o_valid  (w_cnt_valid)
  );

  // Next state, register-port strobe and the response to present next cycle.
  always_comb begin
    w_next   = r_state;
    w_ack_d  = 1'b0;
    w_err_d  = 1'b0;
    w_cnt_d  = r_cnt;
    w_offset = wb_adr_i[11:0];
    w_cfg_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (w_req_valid) begin
            w_cfg_en = 1'b1;
            w_ack_d  = 1'b1;
            if ((wb_cti_i == CTI_INCR) && (wb_bte_i == BTE_LINEAR)) begin
              w_next  = ST_BURST;
              w_cnt_d = wb_adr_i[11:0] + BEAT_STRIDE;
            end else begin
              w_next = ST_SINGLE;
            end
          end else begin
            w_err_d = 1'b1;
            w_next  = ST_ERROR;
          end
        end
      end
      ST_BURST: begin
        w_offset = r_cnt;
        if (!wb_cyc_i) begin
          w_next = ST_IDLE;
        end else if (!wb_stb_i) begin
          // Wait state: keep the previous beat's ack pending until stb returns.
          w_ack_d = r_ack;
        end else if (w_cnt_valid) begin
          w_cfg_en = 1'b1;
          w_ack_d  = 1'b1;
          w_cnt_d  = r_cnt + BEAT_STRIDE;
          if (wb_cti_i == CTI_END) begin
            w_next = ST_SINGLE;
          end
        end else begin
          w_err_d = 1'b1;
          w_next  = ST_ERROR;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, response and read-data registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= w_ack_d;
      r_err   <= w_err_d;
      r_cnt   <= w_cnt_d;
      if (w_cfg_en && !wb_we_i) begin
        r_dat <= cfg_dout;
      end
    end
  end

  // Responses are only shown while the master is actively strobing.
  assign wb_ack_o = r_ack & wb_cyc_i & wb_stb_i;
  assign wb_err_o = r_err & wb_cyc_i & wb_stb_i;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = r_dat;
  assign cfg_addr = {4'h0, w_offset};
  assign cfg_en   = w_cfg_en;
  assign cfg_we   = w_cfg_en & wb_we_i;
  assign cfg_din  = wb_dat_i;

endmodule
